// File: rtl/frame_update_scheduler_if.sv
// Position handshake between the frame update scheduler (master) and game logic (slave).
interface frame_update_scheduler_if;
  logic        oPos_req;
  logic        iPos_ack;
  logic [18:0] iBird_y;
  logic [18:0] iPipe_x;
  logic [18:0] iPipe_y;
  logic        iGameover;

  modport master (
    output oPos_req,
    input  iPos_ack, iBird_y, iPipe_x, iPipe_y, iGameover
  );

  modport slave (
    input  oPos_req,
    output iPos_ack, iBird_y, iPipe_x, iPipe_y, iGameover
  );
endinterface

// File: rtl/frame_update_scheduler.sv
// Requests positions every FRAME_DIV frames, builds sprite boxes and commits them atomically.
// Optional macro FREEZE_ON_GAMEOVER_EN: boxes stop updating after a committed game-over.
module frame_update_scheduler #(
  parameter int FRAME_DIV = 30,
  parameter int BIRD_X    = 320,
  parameter int BIRD_W    = 45,
  parameter int BIRD_H    = 35,
  parameter int PIPE_W    = 54,
  parameter int GAP       = 150,
  parameter int SCREEN_H  = 480
) (
  input  logic                            iVGA_CLK,
  input  logic                            iRST_n,
  input  logic                            iVS,
  input  logic                            iBLANK_n,
  frame_update_scheduler_if.master        pos,
  output logic [75:0]                     oBird_box,
  output logic [75:0]                     oLpipe_box,
  output logic [75:0]                     oUpipe_box,
  output logic                            oGameover,
  output logic                            oUpdate,
  output logic [7:0]                      oMiss_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    CALC_BIRD = 3'd2,
    CALC_PIPE = 3'd3,
    COMMIT    = 3'd4
  } state_t;

  localparam logic [19:0] C_MAX      = 20'h7FFFF;
  localparam logic [19:0] C_BIRD_X   = 20'(BIRD_X);
  localparam logic [19:0] C_BIRD_W   = 20'(BIRD_W);
  localparam logic [19:0] C_BIRD_H   = 20'(BIRD_H);
  localparam logic [19:0] C_PIPE_W   = 20'(PIPE_W);
  localparam logic [19:0] C_HALF_PW  = 20'(PIPE_W / 2);
  localparam logic [19:0] C_HALF_GAP = 20'(GAP / 2);
  localparam logic [19:0] C_SCR      = 20'(SCREEN_H);
  localparam logic [7:0]  C_DIV_M1   = 8'(FRAME_DIV - 1);

  // 20-bit intermediates carry the overflow bit so every result clamps instead of wrapping.
  function automatic logic [18:0] f_sat(input logic [19:0] v);
    logic [19:0] c;
    c = (v > C_MAX) ? C_MAX : v;
    return c[18:0];
  endfunction

  function automatic logic [18:0] f_min(input logic [19:0] a, input logic [19:0] b);
    return f_sat((a < b) ? a : b);
  endfunction

  function automatic logic [18:0] f_sub(input logic [19:0] a, input logic [19:0] b);
    logic [19:0] d;
    d = (a < b) ? '0 : a - b;
    return d[18:0];
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_vs, r_blank;
  logic [7:0]  r_frame_cnt;
  logic        w_vs_fall, w_blank_rise, w_frame_wrap;
  logic [18:0] r_by, r_px, r_py;
  logic        r_go;
  logic [75:0] r_sh_bird, r_sh_lp, r_sh_up;
  logic [18:0] w_pipe_l, w_pipe_r;
  logic [75:0] w_bird_box, w_lp_box, w_up_box;

  assign w_vs_fall    = r_vs & ~iVS;
  assign w_blank_rise = iBLANK_n & ~r_blank;
  assign w_frame_wrap = w_vs_fall && (r_frame_cnt == C_DIV_M1);
  assign pos.oPos_req = (r_state == REQ);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:      if (w_frame_wrap) w_state_nxt = REQ;
      REQ: begin
        if (pos.iPos_ack)      w_state_nxt = CALC_BIRD;
        else if (w_blank_rise) w_state_nxt = IDLE;
      end
      CALC_BIRD: w_state_nxt = CALC_PIPE;
      CALC_PIPE: w_state_nxt = COMMIT;
      COMMIT:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_vs        <= 1'b0;
      r_blank     <= 1'b0;
      r_frame_cnt <= '0;
      oMiss_cnt   <= '0;
    end else begin
      r_vs    <= iVS;
      r_blank <= iBLANK_n;
      if (w_vs_fall) r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + 8'd1;
      if ((r_state == REQ) && !pos.iPos_ack && w_blank_rise && (oMiss_cnt != 8'hFF))
        oMiss_cnt <= oMiss_cnt + 8'd1;
    end
  end

  assign w_bird_box = {f_sat(C_BIRD_X), f_sat(C_BIRD_X + C_BIRD_W), r_by,
                       f_min({1'b0, r_by} + C_BIRD_H, C_SCR)};
  assign w_pipe_l   = f_sub({1'b0, r_px}, C_HALF_PW);
  assign w_pipe_r   = f_sat({1'b0, w_pipe_l} + C_PIPE_W);
  assign w_lp_box   = {w_pipe_l, w_pipe_r, f_min({1'b0, r_py} + C_HALF_GAP, C_SCR), f_sat(C_SCR)};
  assign w_up_box   = {w_pipe_l, w_pipe_r, 19'd0, f_sub({1'b0, r_py}, C_HALF_GAP)};

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_by      <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_go      <= 1'b0;
      r_sh_bird <= '0;
      r_sh_lp   <= '0;
      r_sh_up   <= '0;
    end else begin
      if ((r_state == REQ) && pos.iPos_ack) begin
        r_by <= pos.iBird_y;
        r_px <= pos.iPipe_x;
        r_py <= pos.iPipe_y;
        r_go <= pos.iGameover;
      end
      if (r_state == CALC_BIRD) r_sh_bird <= w_bird_box;
      if (r_state == CALC_PIPE) begin
        r_sh_lp <= w_lp_box;
        r_sh_up <= w_up_box;
      end
    end
  end

`ifdef FREEZE_ON_GAMEOVER_EN
  logic r_frozen;
`endif

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oBird_box  <= '0;
      oLpipe_box <= '0;
      oUpipe_box <= '0;
      oGameover  <= 1'b0;
      oUpdate    <= 1'b0;
`ifdef FREEZE_ON_GAMEOVER_EN
      r_frozen   <= 1'b0;
`endif
    end else begin
      oUpdate <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        oGameover <= r_go;
`ifdef FREEZE_ON_GAMEOVER_EN
        // Freeze is sticky: the commit carrying game-over still lands, later ones do not.
        if (!r_frozen) begin
          oBird_box  <= r_sh_bird;
          oLpipe_box <= r_sh_lp;
          oUpipe_box <= r_sh_up;
        end
        r_frozen <= r_frozen | r_go;
`else
        oBird_box  <= r_sh_bird;
        oLpipe_box <= r_sh_lp;
        oUpipe_box <= r_sh_up;
`endif
      end
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench: table of position vectors plus hand-written timeout, reset and freeze sequences.
module tb_frame_update_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        blank_n = 1'b0;
  logic [75:0] bird_box, lpipe_box, upipe_box;
  logic        gameover, update;
  logic [7:0]  miss_cnt;
  int          checks = 0;
  int          errors = 0;

  frame_update_scheduler_if pif ();

  frame_update_scheduler dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .iVS        (vs),
    .iBLANK_n   (blank_n),
    .pos        (pif),
    .oBird_box  (bird_box),
    .oLpipe_box (lpipe_box),
    .oUpipe_box (upipe_box),
    .oGameover  (gameover),
    .oUpdate    (update),
    .oMiss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] by, px, py;
    logic        go;
    logic [75:0] eb, el, eu;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [75:0] box(input int l, input int r, input int t, input int b);
    return {19'(l), 19'(r), 19'(t), 19'(b)};
  endfunction

  task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One vsync falling edge; returns at the negedge after the detecting posedge.
  task automatic frame();
    @(negedge clk) vs = 1'b0;
    @(negedge clk) vs = 1'b1;
  endtask

  task automatic next_req(input int exp_frames);
    int n;
    n = 0;
    while (pif.oPos_req !== 1'b1 && n < 40) begin
      frame();
      n++;
    end
    chk("frames_to_req", 76'(n), 76'(exp_frames));
  endtask

  task automatic do_update(input logic [18:0] by, input logic [18:0] px, input logic [18:0] py,
                           input logic go, input logic blank);
    @(negedge clk);
    pif.iBird_y = by; pif.iPipe_x = px; pif.iPipe_y = py; pif.iGameover = go;
    pif.iPos_ack = 1'b1;
    blank_n = blank;
    @(negedge clk);
    pif.iPos_ack = 1'b0;
    blank_n = 1'b0;
    chk("req_drop_after_ack", 76'(pif.oPos_req), 76'(0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("update_lat_%0d", k), 76'(update), 76'(k == 3));
    end
  endtask

  task automatic chk_boxes(input string nm, input logic [75:0] eb, input logic [75:0] el,
                           input logic [75:0] eu);
    chk({nm, "_bird"}, bird_box, eb);
    chk({nm, "_lpipe"}, lpipe_box, el);
    chk({nm, "_upipe"}, upipe_box, eu);
  endtask

  initial begin
    vecs[0] = '{19'd100, 19'd400, 19'd240, 1'b0,
                box(320, 365, 100, 135), box(373, 427, 315, 480), box(373, 427, 0, 165)};
    vecs[1] = '{19'd470, 19'd10, 19'd50, 1'b0,
                box(320, 365, 470, 480), box(0, 54, 125, 480), box(0, 54, 0, 0)};
    vecs[2] = '{19'd0, 19'd27, 19'd75, 1'b0,
                box(320, 365, 0, 35), box(0, 54, 150, 480), box(0, 54, 0, 0)};
    vecs[3] = '{19'd460, 19'd600, 19'd450, 1'b0,
                box(320, 365, 460, 480), box(573, 627, 480, 480), box(573, 627, 0, 375)};
    vecs[4] = '{19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b0,
                box(320, 365, 524287, 480), box(524260, 524287, 480, 480),
                box(524260, 524287, 0, 524212)};

    pif.iPos_ack = 1'b0; pif.iBird_y = '0; pif.iPipe_x = '0; pif.iPipe_y = '0;
    pif.iGameover = 1'b0;
    repeat (3) @(negedge clk);
    chk_boxes("reset", '0, '0, '0);
    chk("reset_req", 76'(pif.oPos_req), 76'(0));
    chk("reset_miss", 76'(miss_cnt), 76'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      next_req(30);
      do_update(vecs[i].by, vecs[i].px, vecs[i].py, vecs[i].go, 1'b0);
      chk_boxes($sformatf("vec%0d", i), vecs[i].eb, vecs[i].el, vecs[i].eu);
      chk($sformatf("vec%0d_go", i), 76'(gameover), 76'(vecs[i].go));
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_end", i), 76'(update), 76'(0));
    end

    for (int i = 0; i < 300; i++) begin
      next_req(30);
      blank_n = 1'b1;
      @(negedge clk);
      blank_n = 1'b0;
      chk("timeout_req", 76'(pif.oPos_req), 76'(0));
      chk($sformatf("timeout_miss_%0d", i), 76'(miss_cnt), 76'((i < 255) ? i + 1 : 255));
      if (i == 0 || i == 299) chk_boxes("timeout", vecs[4].eb, vecs[4].el, vecs[4].eu);
    end

    next_req(30);
    do_update(vecs[0].by, vecs[0].px, vecs[0].py, 1'b0, 1'b1);
    chk_boxes("ack_blank", vecs[0].eb, vecs[0].el, vecs[0].eu);
    chk("ack_blank_miss", 76'(miss_cnt), 76'(255));

    next_req(30);
    chk("req_before_reset", 76'(pif.oPos_req), 76'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 76'(pif.oPos_req), 76'(0));
    chk_boxes("async_rst", '0, '0, '0);
    chk("async_rst_miss", 76'(miss_cnt), 76'(0));
    chk("async_rst_go", 76'(gameover), 76'(0));
    chk("async_rst_upd", 76'(update), 76'(0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    next_req(30);

    do_update(vecs[0].by, vecs[0].px, vecs[0].py, 1'b1, 1'b0);
    chk_boxes("go_commit", vecs[0].eb, vecs[0].el, vecs[0].eu);
    chk("go_commit_flag", 76'(gameover), 76'(1));
    next_req(30);
    do_update(19'd200, vecs[0].px, vecs[0].py, 1'b0, 1'b0);
    chk("post_go_flag", 76'(gameover), 76'(0));
`ifdef FREEZE_ON_GAMEOVER_EN
    chk_boxes("frozen", vecs[0].eb, vecs[0].el, vecs[0].eu);
`else
    chk_boxes("unfrozen", box(320, 365, 200, 235), vecs[0].el, vecs[0].eu);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Sequences position updates into the VGA sprite renderer.
- Once every FRAME_DIV frames, at vertical sync, it requests fresh object positions from game logic over a req/ack handshake.
- It then computes sprite bounding boxes over several cycles and commits all of them atomically, so the renderer never sees a half-updated frame.
- Sits between the game-logic registers and the VGA controller's sprite address generator, on the VGA pixel clock.

Parameters:
- FRAME_DIV, 30, frames between update attempts (2..255)
- BIRD_X, 320, fixed bird left column
- BIRD_W, 45, bird width in pixels
- BIRD_H, 35, bird height in pixels
- PIPE_W, 54, pipe width in pixels
- GAP, 150, vertical gap between pipes
- SCREEN_H, 480, screen height

Ports:
- iVGA_CLK  in  1  pixel clock
- iRST_n  in  1  reset
- iVS  in  1  vsync from sync generator, active low
- iBLANK_n  in  1  high during active video
- oPos_req  out  1  position request to game logic
- iPos_ack  in  1  game logic: position inputs valid this cycle
- iBird_y  in  19  bird top row
- iPipe_x  in  19  pipe centre column
- iPipe_y  in  19  gap centre row
- iGameover  in  1  game-over flag
- oBird_box  out  76  {left,right,top,bottom}, 19 b each
- oLpipe_box  out  76  lower pipe box, same packing
- oUpipe_box  out  76  upper pipe box, same packing
- oGameover  out  1  committed game-over flag
- oUpdate  out  1  one-cycle pulse on commit
- oMiss_cnt  out  8  missed-update counter, saturating

Behaviour:
- Clock and reset: one clock, iVGA_CLK, rising edge. Reset iRST_n is asynchronous, active-low.
- Reset values: all boxes 0, oGameover 0, oUpdate 0, oPos_req 0, oMiss_cnt 0, frame counter 0, state IDLE. Reset asserted mid-handshake drops oPos_req immediately.
- Frame edge: a registered copy of iVS detects the 1->0 edge. Each edge increments the frame counter. When the counter reaches FRAME_DIV-1 on an edge, it wraps to 0 and the FSM moves IDLE->REQ.
- Edges in any state other than IDLE only advance the counter.
- FSM states: IDLE, REQ, CALC_BIRD, CALC_PIPE, COMMIT.
- REQ:
  - oPos_req is high.
  - On the first cycle with iPos_ack=1, the four position inputs are captured into shadow registers and the FSM goes to CALC_BIRD. oPos_req is low from the next cycle.
  - If iBLANK_n rises (0->1, registered) before ack: abort to IDLE, drop req, oMiss_cnt+1 saturating at 255, committed boxes unchanged.
  - Ack and the iBLANK_n rise in the same cycle: ack wins.
- CALC_BIRD (1 cycle), shadow bird box:
  - left=BIRD_X, right=BIRD_X+BIRD_W
  - top=y, bottom=min(y+BIRD_H, SCREEN_H)
- CALC_PIPE (1 cycle), shadow pipe boxes:
  - Both pipes: L = (x<PIPE_W/2) ? 0 : x-PIPE_W/2; R = L+PIPE_W.
  - Lower pipe: top = min(py+GAP/2, SCREEN_H), bottom = SCREEN_H.
  - Upper pipe: top = 0, bottom = (py<GAP/2) ? 0 : py-GAP/2.
  - PIPE_W/2 and GAP/2 truncate. All arithmetic is 19-bit unsigned and saturates, never wraps.
- COMMIT (1 cycle): all three boxes and oGameover load from the shadows together; oUpdate=1 for this cycle only; next state IDLE.
- Latency: ack to oUpdate is 3 cycles. Outputs are stable between commits.

Optional Feature:
- Macro: FREEZE_ON_GAMEOVER_EN.
- Defined: once oGameover=1, later COMMITs leave all three boxes unchanged. oGameover, oUpdate and the handshake still operate normally. Only reset clears the freeze.
- Undefined: boxes update on every COMMIT regardless of oGameover.

Test Plan:
- Basic update: FRAME_DIV=30, ack one cycle after req with bird_y=100, pipe_x=400, pipe_y=240 -> oUpdate 3 cycles after ack; bird {320,365,100,135}; lower {373,427,315,480}; upper {373,427,0,165}.
- Frame divider: 90 vsync edges with ack always ready -> exactly 3 oUpdate pulses, on edges 30, 60, 90; oPos_req never high elsewhere.
- Saturation: pipe_x=10, pipe_y=50, bird_y=470 -> lower/upper left 0, right 54; upper bottom 0; bird bottom 480.
- Timeout: ack held low, iBLANK_n rises -> req drops, oMiss_cnt 0->1, boxes unchanged. Repeat 300 times -> oMiss_cnt stays 255. Ack and blank rise in the same cycle -> commit happens, no miss counted.
- Reset mid-REQ: deassert iRST_n while oPos_req=1 -> req 0 asynchronously, all outputs 0. After release, the first request occurs 30 frames later.
- FREEZE_ON_GAMEOVER_EN: commit with iGameover=1, then commit with bird_y=200 -> defined: bird top stays at its prior value and oUpdate still pulses; undefined: bird top becomes 200.
